uart_note_encoder: RTL and testbench

Serial UART transmitter that sends the current 7-bit note vector as one 8N1 frame per update. It drives a PMOD pin, and its frames are decoded by the UART note decoder on the receiving board. A frame is sent on note change, on explicit request, and on a periodic refresh so a receiver that joins late resynchronises. It sits in the 100 MHz domain; note_in comes from the local keyboard switches or from the game controller.

---
 rtl/uart_note_encoder_if.sv | 30 +++
 rtl/uart_note_encoder.sv | 155 +++++++++++++++
 tb/tb_uart_note_encoder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_note_encoder_if.sv
// uart_note_encoder_if
// Bundles the note-encoder data/handshake signals.
//   note_in         : 7-bit note vector to transmit
//   send_in         : single-cycle send request
//   enable_in       : 1 = new frames may start
//   tx_out          : UART serial line, idle high
//   busy_out        : high while a frame is in flight
//   done_out        : one-cycle pulse at end of stop bit
//   frame_count_out : completed frame counter (wraps)
// master: the note source (drives requests, observes status).
// slave : the encoder itself.
interface uart_note_encoder_if;
  logic [6:0] note_in;
  logic       send_in;
  logic       enable_in;
  logic       tx_out;
  logic       busy_out;
  logic       done_out;
  logic [7:0] frame_count_out;

  modport master (
    output note_in, send_in, enable_in,
    input  tx_out, busy_out, done_out, frame_count_out
  );

  modport slave (
    input  note_in, send_in, enable_in,
    output tx_out, busy_out, done_out, frame_count_out
  );
endinterface

// File: rtl/uart_note_encoder.sv
// uart_note_encoder
// 8N1 UART transmitter for the 7-bit note vector. A frame goes out when the
// note changes, on send_in, or on a periodic refresh so a late-joining
// receiver resynchronises. Data byte = {even-parity bit, note[6:0]}.
// Ports:
//   clk_in : system clock
//   rst_in : synchronous active-high reset
//   bus    : uart_note_encoder_if.slave (note/send/enable in, tx/busy/done/count out)
module uart_note_encoder #(
  parameter int CLKS_PER_BIT   = 868,
  parameter int REFRESH_CYCLES = 10_000_000
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  uart_note_encoder_if.slave        bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int RW = $clog2(REFRESH_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_baud_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shreg;
  logic [6:0]    r_last_note;
  logic          r_pending;
  logic [RW-1:0] r_refresh_cnt;
  logic          r_tx;
  logic          r_busy;
  logic          r_done;
  logic [7:0]    r_frame_count;

  logic          w_event;
  logic          w_trig;
  logic          w_start;
  logic          w_bit_end;
  logic          w_refresh_fire;
  logic [2:0]    w_next_idx;

  // Bit 7 makes the total number of ones in the byte even.
  function automatic logic [7:0] f_frame_byte(input logic [6:0] note);
    return {^note, note};
  endfunction

  // Trigger, bit-timing and refresh decode.
  always_comb begin
    w_event        = bus.send_in | (bus.note_in != r_last_note);
    w_trig         = w_event | r_pending;
    w_start        = (r_state == S_IDLE) & bus.enable_in & w_trig;
    w_bit_end      = (r_baud_cnt == CW'(CLKS_PER_BIT - 1));
    w_refresh_fire = bus.enable_in & (r_refresh_cnt == RW'(REFRESH_CYCLES - 1));
    w_next_idx     = r_bit_idx + 3'd1;
  end

  // Transmit FSM, pending/refresh bookkeeping and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state       <= S_IDLE;
      r_baud_cnt    <= '0;
      r_bit_idx     <= 3'd0;
      r_shreg       <= 8'd0;
      r_last_note   <= 7'd0;
      r_pending     <= 1'b0;
      r_refresh_cnt <= '0;
      r_tx          <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_frame_count <= 8'd0;
    end else begin
      r_done <= 1'b0;

      // A frame start restarts the refresh interval; disable holds it at zero.
      if (w_start || !bus.enable_in || w_refresh_fire) begin
        r_refresh_cnt <= '0;
      end else begin
        r_refresh_cnt <= r_refresh_cnt + RW'(1);
      end

      // Events during a frame collapse into one follow-up frame.
      if (w_start) begin
        r_pending <= 1'b0;
      end else if (w_refresh_fire || ((r_state != S_IDLE) && w_event)) begin
        r_pending <= 1'b1;
      end else begin
        r_pending <= r_pending;
      end

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_shreg     <= f_frame_byte(bus.note_in);
            r_last_note <= bus.note_in;
            r_baud_cnt  <= '0;
            r_tx        <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_tx       <= r_shreg[0];
            r_state    <= S_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= w_next_idx;
              r_tx      <= r_shreg[w_next_idx];
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_baud_cnt    <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b1;
            r_frame_count <= r_frame_count + 8'd1;
            r_state       <= S_IDLE;
          end else begin
            r_baud_cnt <= r_baud_cnt + CW'(1);
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.tx_out          = r_tx;
  assign bus.busy_out        = r_busy;
  assign bus.done_out        = r_done;
  assign bus.frame_count_out = r_frame_count;

endmodule

// File: tb/tb_uart_note_encoder.sv
// tb_uart_note_encoder
// Self-checking bench for uart_note_encoder (CLKS_PER_BIT=4, REFRESH_CYCLES=100).
// Expected bytes are queued when stimulus is applied; a line monitor decodes
// each frame, checks bit timing, busy/done behaviour and frame count, and
// pops the queue at the end of every stop bit.
module tb_uart_note_encoder;

  localparam int CPB = 4;
  localparam int RC  = 100;

  logic clk;
  logic rst_in;

  uart_note_encoder_if bus ();

  uart_note_encoder #(
    .CLKS_PER_BIT   (CPB),
    .REFRESH_CYCLES (RC)
  ) dut (
    .clk_in (clk),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int n_checks;
  int n_fail;
  logic [7:0] sb[$];

  int         mon_c;
  int         mon_b;
  int         mon_p;
  int         mon_frames;
  bit         mon_active;
  logic [7:0] mon_byte;
  logic       mon_bitval;

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Even-parity byte computed by counting ones.
  function automatic logic [7:0] exp_byte(input logic [6:0] n);
    int ones;
    ones = 0;
    for (int i = 0; i < 7; i++) ones += int'(n[i]);
    return {ones[0], n};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (bus.done_out !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check_value({tag, "_done_seen"}, 32'(bus.done_out), 32'd1);
  endtask

  task automatic idle_window(input string tag, input int cycles);
    logic quiet;
    quiet = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.tx_out !== 1'b1 || bus.busy_out !== 1'b0) quiet = 1'b0;
    end
    check_value(tag, 32'(quiet), 32'd1);
  endtask

  // Line monitor: decodes frames on the falling clock edge.
  always @(negedge clk) begin
    if (rst_in) begin
      mon_active = 1'b0;
      mon_frames = 0;
    end else if (!mon_active) begin
      if (bus.done_out) check_value("done_outside_frame", 32'(bus.done_out), 32'd0);
      if (bus.tx_out == 1'b0) begin
        mon_active = 1'b1;
        mon_c      = 0;
        mon_byte   = 8'h00;
        mon_bitval = 1'b0;
        check_value("busy_at_start", 32'(bus.busy_out), 32'd1);
      end
    end else begin
      mon_c++;
      if (mon_c == 10 * CPB) begin
        check_value("done_after_stop", 32'(bus.done_out), 32'd1);
        check_value("busy_after_stop", 32'(bus.busy_out), 32'd0);
        check_value("line_idle_after_stop", 32'(bus.tx_out), 32'd1);
        mon_frames++;
        check_value("frame_count_track", 32'(bus.frame_count_out), 32'(mon_frames % 256));
        check_value("frame_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) check_value("frame_byte", 32'(mon_byte), 32'(sb.pop_front()));
        mon_active = 1'b0;
      end else begin
        mon_b = mon_c / CPB;
        mon_p = mon_c % CPB;
        if (bus.busy_out !== 1'b1) check_value("busy_in_frame", 32'(bus.busy_out), 32'd1);
        if (bus.done_out) check_value("done_in_frame", 32'(bus.done_out), 32'd0);
        if (mon_p == 0) begin
          mon_bitval = bus.tx_out;
          if (mon_b >= 1 && mon_b <= 8) mon_byte[mon_b-1] = bus.tx_out;
          if (mon_b == 9) check_value("stop_bit", 32'(bus.tx_out), 32'd1);
        end else if (bus.tx_out !== mon_bitval) begin
          check_value("bit_held", 32'(bus.tx_out), 32'(mon_bitval));
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    logic ok;
    n_checks = 0;
    n_fail   = 0;
    rst_in        = 1'b1;
    bus.note_in   = 7'd0;
    bus.send_in   = 1'b0;
    bus.enable_in = 1'b1;
    repeat (3) tick();
    check_value("rst_tx", 32'(bus.tx_out), 32'd1);
    check_value("rst_busy", 32'(bus.busy_out), 32'd0);
    check_value("rst_done", 32'(bus.done_out), 32'd0);
    check_value("rst_count", 32'(bus.frame_count_out), 32'd0);

    // 1: refresh frame from an unchanged zero note
    sb.push_back(exp_byte(7'd0));
    rst_in = 1'b0;
    ok = 1'b1;
    for (int i = 1; i <= RC; i++) begin
      tick();
      if (bus.tx_out !== 1'b1 || bus.busy_out !== 1'b0) ok = 1'b0;
    end
    check_value("t1_idle_before_refresh", 32'(ok), 32'd1);
    tick();
    check_value("t1_refresh_start", 32'(bus.tx_out), 32'd0);
    wait_done("t1");
    check_value("t1_count", 32'(bus.frame_count_out), 32'd1);

    // 2: note 0000100 straight out of reset -> 0x84
    rst_in = 1'b1;
    sb.delete();
    repeat (2) tick();
    bus.note_in = 7'b0000100;
    sb.push_back(8'h84);
    rst_in = 1'b0;
    tick();
    check_value("t2_latency", 32'(bus.tx_out), 32'd0);
    check_value("t2_busy", 32'(bus.busy_out), 32'd1);

    // 3: two note changes mid-DATA collapse into one follow-up (0xA0)
    repeat (12) tick();
    bus.note_in = 7'b0000011;
    repeat (4) tick();
    bus.note_in = 7'b0100000;
    sb.push_back(8'hA0);
    wait_done("t2");
    check_value("t2_count", 32'(bus.frame_count_out), 32'd1);
    tick();
    check_value("t3_followup_start", 32'(bus.tx_out), 32'd0);
    wait_done("t3");
    check_value("t3_count", 32'(bus.frame_count_out), 32'd2);
    idle_window("t3_single_followup", 20);

    // 4: send_in together with a note change -> one frame 0x81
    bus.note_in = 7'b0000001;
    bus.send_in = 1'b1;
    sb.push_back(exp_byte(7'b0000001));
    tick();
    bus.send_in = 1'b0;
    check_value("t4_start", 32'(bus.tx_out), 32'd0);
    wait_done("t4");
    check_value("t4_count", 32'(bus.frame_count_out), 32'd3);
    idle_window("t4_no_second_frame", 20);

    // 5: reset during DATA bit 3 aborts the frame
    bus.note_in = 7'b1010101;
    sb.push_back(exp_byte(7'b1010101));
    tick();
    check_value("t5_start", 32'(bus.tx_out), 32'd0);
    repeat (17) tick();
    rst_in = 1'b1;
    sb.delete();
    tick();
    check_value("t5_tx", 32'(bus.tx_out), 32'd1);
    check_value("t5_busy", 32'(bus.busy_out), 32'd0);
    check_value("t5_count", 32'(bus.frame_count_out), 32'd0);
    bus.note_in = 7'd0;
    repeat (2) tick();
    check_value("t5_no_done", 32'(bus.done_out), 32'd0);
    rst_in = 1'b0;

    // 6: disable during START, note change while disabled, re-enable
    bus.send_in = 1'b1;
    sb.push_back(8'h00);
    tick();
    bus.send_in = 1'b0;
    check_value("t6_start", 32'(bus.tx_out), 32'd0);
    tick();
    bus.enable_in = 1'b0;
    wait_done("t6");
    check_value("t6_count", 32'(bus.frame_count_out), 32'd1);
    bus.note_in = 7'b0001000;
    idle_window("t6_disabled_quiet", 30);
    sb.push_back(8'h88);
    bus.enable_in = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (!ok) begin
        tick();
        if (bus.tx_out === 1'b0) ok = 1'b1;
      end
    end
    check_value("t6_reenable_start", 32'(ok), 32'd1);
    wait_done("t6b");
    check_value("t6b_count", 32'(bus.frame_count_out), 32'd2);
    repeat (3) tick();
    check_value("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
